priority_decoder_seq: RTL and testbench
=======================================

Name: priority_decoder_seq

Overview:
Sequential decoder that is the counterpart of the team's 16-to-4 priority encoder. It accepts a 4-bit index over a valid/ready handshake and drives the matching one-hot line of a 16-bit output. The line is held for a programmable number of cycles, then a programmable idle gap follows. The block drives one-hot select/strobe lines from encoded indices produced elsewhere in the design.

Parameters:
IN_W, 4, index width.
OUT_W, 16, one-hot output width; must equal 2**IN_W.
HOLD_CYCLES, 4, cycles a decoded line stays asserted; legal range 1 or more.
GAP_CYCLES, 1, forced idle cycles after a natural release; legal range 0 or more.

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
enable  input  1  block enable; low aborts any drive and blocks new acceptance.
in_valid  input  1  decode_in is valid this cycle.
in_ready  output  1  block can accept an index this cycle.
decode_in  input  IN_W  index to decode.
decode_out  output  OUT_W  registered one-hot output; all-zero when not driving.
out_valid  output  1  high exactly while decode_out is non-zero.
done  output  1  one-cycle pulse on natural release of a line.

Behaviour:
- Reset (asynchronous, immediate, no clock required):
  - decode_out=0, out_valid=0, done=0.
  - State IDLE, counter=0, latched index=0.
  - After rst deasserts, in_ready follows enable.
- in_ready is combinational: (state==IDLE) && enable.
- Accept occurs on a rising edge where in_valid && in_ready.
  - decode_in is sampled only at accept; it is ignored at all other times.
- States are IDLE, DRIVE and GAP. The counter is sized for max(HOLD_CYCLES, GAP_CYCLES).
- IDLE:
  - On accept, go to DRIVE, load counter=HOLD_CYCLES-1, register decode_out=1<<decode_in, out_valid=1.
  - Latency: decode_out is visible in the cycle immediately after the accept edge.
- DRIVE:
  - counter!=0: decrement; outputs hold.
  - counter==0 at edge: decode_out=0, out_valid=0, done=1 for the next cycle.
  - Then go to GAP with counter=GAP_CYCLES-1 if GAP_CYCLES>0; otherwise go to IDLE.
  - decode_out is therefore asserted for exactly HOLD_CYCLES cycles.
- GAP:
  - counter!=0: decrement.
  - counter==0 at edge: go to IDLE.
  - Outputs stay zero throughout.
- done is high only for the single cycle following the DRIVE exit edge, and low in all other cycles.
- Throughput: minimum accept-to-accept spacing is HOLD_CYCLES+GAP_CYCLES+1 edges.
- enable low while in DRIVE or GAP:
  - At the next edge, go to IDLE, decode_out=0, out_valid=0, counter=0.
  - done stays 0 on abort.
  - in_ready remains 0 until enable returns high.
- enable low while in IDLE: no acceptance; outputs stay zero.
- Every value of decode_in is legal: index 0 yields 0x0001, index 15 yields 0x8000.
- decode_out is never multi-hot in any cycle.
- in_valid high while in_ready is low: no effect; the source must hold in_valid until accepted.
- Reset asserted mid-DRIVE: decode_out clears asynchronously the same cycle, with no done pulse.

Test Plan:
1. Assert rst with no clock running, enable=1 -> decode_out=0x0000, out_valid=0, done=0 immediately; after rst release, in_ready=1.
2. HOLD=4, GAP=1, accept decode_in=5 at edge E0 -> decode_out=0x0020 and out_valid=1 in cycles E0..E4 (4 cycles); zero from E4; done=1 only in cycle E4..E5; in_ready=0 until E5, then 1; next accept possible at E6.
3. Accept decode_in=0, then decode_in=15 at earliest legal spacing -> 0x0001 for 4 cycles, 2 zero cycles, then 0x8000 for 4 cycles; never multi-hot; two done pulses.
4. Accept decode_in=9, drop enable after 2 drive cycles -> decode_out=0 at the next edge, done stays 0, in_ready=0 while enable low, 1 the cycle after enable returns.
5. Accept decode_in=3, then hold in_valid=1 while cycling decode_in through 7, 8, 12 during DRIVE/GAP -> output stays 0x0008 for 4 cycles; the value present at the next in_ready cycle (e.g. 12 -> 0x1000) is the one accepted.
6. GAP_CYCLES=0, HOLD_CYCLES=1, in_valid held high with decode_in=2 -> 0x0004 pulses 1 cycle on, 1 cycle off repeatedly; done pulses in each off cycle.

Source files
------------

// File: rtl/priority_decoder_seq_if.sv
// Handshake and output bundle for priority_decoder_seq.
// The master side supplies the index and enable; the slave side is the decoder.
interface priority_decoder_seq_if #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 16
);
    logic             enable;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  decode_in;
    logic [OUT_W-1:0] decode_out;
    logic             out_valid;
    logic             done;

    modport master (
        output enable, in_valid, decode_in,
        input  in_ready, decode_out, out_valid, done
    );

    modport slave (
        input  enable, in_valid, decode_in,
        output in_ready, decode_out, out_valid, done
    );
endinterface

// File: rtl/priority_decoder_seq.sv
// Sequential index-to-one-hot decoder: an accepted index drives its one-hot
// line for HOLD_CYCLES cycles, then the block idles for GAP_CYCLES cycles
// before it can accept again. Dropping enable aborts any drive or gap.
module priority_decoder_seq #(
    parameter int IN_W        = 4,
    parameter int OUT_W       = 16,
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    priority_decoder_seq_if.slave bus
);
    // Counter only ever holds reload values, i.e. at most max(HOLD,GAP)-1.
    localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] count_reg;
    logic [OUT_W-1:0] decode_reg;
    logic             valid_reg;
    logic             done_reg;
    logic [OUT_W-1:0] onehot;
    logic             accept;

    // One comparator per output line; exactly one matches any in-range index.
    for (genvar gi = 0; gi < OUT_W; gi++) begin : g_onehot
        assign onehot[gi] = (bus.decode_in == IN_W'(gi));
    end

    assign bus.in_ready   = (state_reg == IDLE) && bus.enable;
    assign accept         = bus.in_valid && bus.in_ready;
    assign bus.decode_out = decode_reg;
    assign bus.out_valid  = valid_reg;
    assign bus.done       = done_reg;

    // Control FSM with registered outputs; abort on enable low beats every
    // other transition, including the natural end of a drive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            count_reg  <= '0;
            decode_reg <= '0;
            valid_reg  <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (!bus.enable && (state_reg != IDLE)) begin
                state_reg  <= IDLE;
                count_reg  <= '0;
                decode_reg <= '0;
                valid_reg  <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (accept) begin
                            state_reg  <= DRIVE;
                            count_reg  <= HOLD_LOAD;
                            decode_reg <= onehot;
                            valid_reg  <= 1'b1;
                        end
                    end
                    DRIVE: begin
                        if (count_reg != '0) begin
                            count_reg <= count_reg - CNT_W'(1);
                        end else begin
                            decode_reg <= '0;
                            valid_reg  <= 1'b0;
                            done_reg   <= 1'b1;
                            if (GAP_CYCLES > 0) begin
                                state_reg <= GAP;
                                count_reg <= GAP_LOAD;
                            end else begin
                                state_reg <= IDLE;
                            end
                        end
                    end
                    GAP: begin
                        if (count_reg != '0) begin
                            count_reg <= count_reg - CNT_W'(1);
                        end else begin
                            state_reg <= IDLE;
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_priority_decoder_seq.sv
// Bench for priority_decoder_seq: two instances (HOLD=4/GAP=1 and HOLD=1/GAP=0)
// share one stimulus stream; a transaction-level predictor fills a scoreboard
// and a separate monitor checks each output run against it.
module tb_priority_decoder_seq;
    localparam int H0 = 4;
    localparam int G0 = 1;
    localparam int H1 = 1;
    localparam int G1 = 0;

    typedef struct {
        int          cfg;
        logic [15:0] onehot;
        int          len;
        bit          done;
    } exp_t;

    logic       clk = 1'b0;
    bit         clk_run = 1'b0;
    logic       rst = 1'b0;
    logic       enable = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] decode_in = 4'd0;

    int  checks = 0;
    int  errors = 0;
    bit  tb_done = 1'b0;
    bit  stim_timeout = 1'b0;

    exp_t sb[$];
    int   n_edge = 0;
    int   acc_edge [2];
    int   next_ok [2];
    int   last_idx [2];
    bit   exp_idle [2];

    priority_decoder_seq_if #(.IN_W(4), .OUT_W(16)) if_a ();
    priority_decoder_seq_if #(.IN_W(4), .OUT_W(16)) if_b ();

    assign if_a.enable    = enable;
    assign if_a.in_valid  = in_valid;
    assign if_a.decode_in = decode_in;
    assign if_b.enable    = enable;
    assign if_b.in_valid  = in_valid;
    assign if_b.decode_in = decode_in;

    priority_decoder_seq #(.IN_W(4), .OUT_W(16), .HOLD_CYCLES(H0), .GAP_CYCLES(G0)) dut_a (
        .clk(clk), .rst(rst), .bus(if_a)
    );
    priority_decoder_seq #(.IN_W(4), .OUT_W(16), .HOLD_CYCLES(H1), .GAP_CYCLES(G1)) dut_b (
        .clk(clk), .rst(rst), .bus(if_b)
    );

    logic [15:0] dout [2];
    logic        ov [2];
    logic        dut_done [2];
    logic        ready [2];
    assign dout[0] = if_a.decode_out;
    assign dout[1] = if_b.decode_out;
    assign ov[0] = if_a.out_valid;
    assign ov[1] = if_b.out_valid;
    assign dut_done[0] = if_a.done;
    assign dut_done[1] = if_b.done;
    assign ready[0] = if_a.in_ready;
    assign ready[1] = if_b.in_ready;

    always #5 if (clk_run) clk = ~clk;

    function automatic int hold_of(int k);
        return (k == 0) ? H0 : H1;
    endfunction

    function automatic int gap_of(int k);
        return (k == 0) ? G0 : G1;
    endfunction

    function automatic int next_for(int k, int start);
        for (int i = start; i < sb.size(); i++) begin
            if (sb[i].cfg == k) return i;
        end
        return -1;
    endfunction

    // Predictor: a config accepts at edge a when enabled, valid and no earlier
    // than a_prev + HOLD + GAP + 1; enable low inside that window aborts it.
    initial begin
        for (int k = 0; k < 2; k++) begin
            acc_edge[k] = 0; next_ok[k] = 0; last_idx[k] = -1; exp_idle[k] = 1'b1;
        end
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                n_edge = 0;
                sb.delete();
                for (int k = 0; k < 2; k++) begin
                    acc_edge[k] = 0; next_ok[k] = 0; last_idx[k] = -1; exp_idle[k] = 1'b1;
                end
            end else begin
                for (int k = 0; k < 2; k++) begin
                    bit busy;
                    busy = (n_edge > acc_edge[k]) && (n_edge < next_ok[k]);
                    if (busy && !enable) begin
                        if ((n_edge <= acc_edge[k] + hold_of(k)) && (last_idx[k] >= 0)) begin
                            exp_t t;
                            t = sb[last_idx[k]];
                            t.len  = n_edge - acc_edge[k];
                            t.done = 1'b0;
                            sb[last_idx[k]] = t;
                        end
                        next_ok[k] = n_edge + 1;
                    end else if ((n_edge >= next_ok[k]) && enable && in_valid) begin
                        exp_t e;
                        e.cfg    = k;
                        e.onehot = 16'd1 << decode_in;
                        e.len    = hold_of(k);
                        e.done   = 1'b1;
                        last_idx[k] = sb.size();
                        sb.push_back(e);
                        acc_edge[k] = n_edge;
                        next_ok[k]  = n_edge + hold_of(k) + gap_of(k) + 1;
                    end
                    exp_idle[k] = (n_edge + 1 >= next_ok[k]);
                end
                n_edge++;
            end
        end
    end

    task automatic chk(input string name, input int k, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cfg%0d t=%0t got=%0h exp=%0h", name, k, $time, got, exp);
        end
    endtask

    // Monitor: owns all comparisons and the summary line.
    initial begin
        int  rd [2];
        int  cur [2];
        int  run [2];
        bit  prev_ov [2];
        int  cyc;
        bit  exp_done;
        cyc = 0;
        for (int k = 0; k < 2; k++) begin
            rd[k] = 0; cur[k] = -1; run[k] = 0; prev_ov[k] = 1'b0;
        end
        #3;
        for (int k = 0; k < 2; k++) begin
            chk("rst_noclk_data", k, dout[k], 0);
            chk("rst_noclk_valid", k, ov[k], 0);
            chk("rst_noclk_done", k, dut_done[k], 0);
        end
        while (!tb_done && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            for (int k = 0; k < 2; k++) begin
                if (rst) begin
                    chk("rst_data", k, dout[k], 0);
                    chk("rst_valid", k, ov[k], 0);
                    chk("rst_done", k, dut_done[k], 0);
                    rd[k] = 0; cur[k] = -1; run[k] = 0; prev_ov[k] = 1'b0;
                end else begin
                    exp_done = 1'b0;
                    chk("in_ready", k, ready[k], exp_idle[k] && enable);
                    chk("valid_vs_data", k, ov[k], dout[k] != 16'd0);
                    chk("onehot", k, $countones(dout[k]) <= 1, 1);
                    if (ov[k] && !prev_ov[k]) begin
                        cur[k] = next_for(k, rd[k]);
                        run[k] = 0;
                        if (cur[k] < 0) chk("unexpected_out", k, ov[k], 0);
                        else rd[k] = cur[k] + 1;
                    end
                    if (ov[k]) begin
                        run[k]++;
                        if (cur[k] >= 0) chk("data", k, dout[k], sb[cur[k]].onehot);
                    end
                    if (!ov[k] && prev_ov[k] && cur[k] >= 0) begin
                        chk("hold_len", k, run[k], sb[cur[k]].len);
                        exp_done = sb[cur[k]].done;
                    end
                    chk("done", k, dut_done[k], exp_done);
                    prev_ov[k] = ov[k];
                end
            end
        end
        chk("finished_in_budget", 0, tb_done, 1);
        chk("stim_timeout", 0, stim_timeout, 0);
        for (int k = 0; k < 2; k++) begin
            chk("scoreboard_drained", k, next_for(k, rd[k]), -1);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Present an index and hold it until instance A takes it.
    task automatic send(input logic [3:0] idx);
        bit got;
        got = 1'b0;
        in_valid  = 1'b1;
        decode_in = idx;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (if_a.in_ready) got = 1'b1;
        end
        if (!got) stim_timeout = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        #1 rst = 1'b1;
        #5 clk_run = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // single transaction, then two back-to-back at minimum spacing
        send(4'd5);
        send(4'd0);
        send(4'd15);
        repeat (8) @(posedge clk);
        #1;
        // abort mid-drive
        send(4'd9);
        repeat (2) @(posedge clk);
        #1 enable = 1'b0;
        repeat (3) @(posedge clk);
        #1 enable = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        // index changes while busy are ignored until the next ready cycle
        send(4'd3);
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            decode_in = (i < 2) ? 4'd7 : (i < 4) ? 4'd8 : 4'd12;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        // valid held with a fixed index: free-running repeat
        in_valid  = 1'b1;
        decode_in = 4'd2;
        repeat (12) @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        // asynchronous reset in the middle of a drive
        send(4'd6);
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            enable    = ($urandom_range(0, 15) != 0);
            in_valid  = ($urandom_range(0, 2) != 0);
            decode_in = 4'($urandom_range(0, 15));
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        enable   = 1'b1;
        repeat (20) @(posedge clk);
        #1 tb_done = 1'b1;
    end
endmodule
